alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, multi-cycle successor to the datapath ALU. Add/sub/logic complete in one cycle;
//  multiply and divide are iterative (one bit per cycle) instead of combinational * and /.
//  Sits between register-read and write-back, with valid/ready handshakes on both sides so the
//  control unit can stall on long operations. Adds carry/overflow/div-by-zero flags and remainder.
// PARAMETERS
//  WIDTH      32  operand/result width in bits (>=4)
//  CNT_W      $clog2(WIDTH+1)  iteration-counter width (derived; not overridden)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      operation request valid
//  in_ready     out  1      block can accept a request (high only in IDLE)
//  alu_control  in   4      opcode, sampled on in_valid&&in_ready
//  src1         in   WIDTH  first operand (dividend for DIV/REM)
//  src2         in   WIDTH  second operand (divisor for DIV/REM)
//  out_valid    out  1      result/flags valid; held until out_ready
//  out_ready    in   1      consumer accepts result
//  result       out  WIDTH  operation result
//  zero         out  1      result == 0
//  carry        out  1      ADD: carry-out; SUB: borrow (src1 < src2 unsigned); else 0
//  overflow     out  1      signed overflow for ADD/SUB; MUL: high product half nonzero; else 0
//  div_by_zero  out  1      DIV/REM with src2 == 0
//  illegal_op   out  1      opcode not in table below
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=0, all flags=0,
//   counter and internal operand registers cleared. Reset mid-operation discards the op; no output.
//  Opcodes: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0011 XOR, 1000 MUL (unsigned, low WIDTH bits),
//   1001 DIV (unsigned quotient), 1010 REM (unsigned remainder). Others: result=0, illegal_op=1.
//  Handshake: accept when in_valid&&in_ready; in_ready=0 from the accept edge until the result
//   is consumed (out_valid&&out_ready). Result and flags stay stable while out_valid&&!out_ready.
//  FSM: IDLE -> (single-cycle op | illegal | div-by-zero) DONE; IDLE -> MUL -> DONE;
//   IDLE -> DIV -> DONE; DONE -> IDLE on out_ready. No new request accepted in DONE.
//  Latency (accept edge to out_valid high): single-cycle ops 1 cycle; MUL and DIV/REM WIDTH+1 cycles
//   (WIDTH iterations plus one finalise cycle). out_valid is registered, never combinational from inputs.
//  MUL: shift-add over 2*WIDTH accumulator; result=acc[WIDTH-1:0]; overflow=|acc[2W-1:W].
//  DIV/REM: restoring division, one quotient bit per cycle, MSB first, (WIDTH+1)-bit partial remainder.
//  Div by zero: no iteration; DIV result={WIDTH{1'b1}}, REM result=src1, div_by_zero=1, latency 1.
//  zero is computed from the registered final result for every opcode, including illegal (zero=1).
//  Back-to-back: with out_ready tied high, DONE->IDLE takes one cycle; next accept the cycle after.
//  in_valid while busy is ignored (not queued); src inputs need only be valid at the accept edge.
// STRUCTURE
//  Package alu_pkg: opcode localparams (ALU_ADD..ALU_REM), FSM state encoding (IDLE/MUL/DIV/DONE).
//  One sub-module: alu_muldiv_iter (shared counter, accumulator/remainder, start/done pulses);
//   top level holds the handshake FSM, single-cycle ops, flag generation and output registers.
// TESTING
//  1. Reset mid-MUL (rst_n low at iteration 5) -> out_valid=0, in_ready=1, result=0 immediately.
//  2. ADD 0xFFFFFFFF+1 -> result=0, zero=1, carry=1, overflow=0, out_valid 1 cycle after accept.
//  3. SUB 0x80000000-1 -> result=0x7FFFFFFF, overflow=1, carry=0; SUB 3-5 -> 0xFFFFFFFE, carry=1.
//  4. MUL 0x00010000*0x00010000 -> result=0, overflow=1, zero=1, out_valid exactly 33 cycles after accept.
//  5. DIV 100/7 -> 14; REM 100/7 -> 2; DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, div_by_zero=1, latency 1.
//  6. out_ready held low 10 cycles after MUL done -> result stable, in_ready=0, new in_valid ignored;
//     opcode 4'b1111 -> illegal_op=1, result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM state
// encoding and the packed flag payload carried alongside each result.
package alu_pkg;

   localparam int unsigned OP_W    = 4;
   localparam int unsigned STATE_W = 2;

   // Opcodes (alu_control)
   localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
   localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
   localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
   localparam logic [OP_W-1:0] ALU_XOR = 4'b0011;
   localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;
   localparam logic [OP_W-1:0] ALU_MUL = 4'b1000;
   localparam logic [OP_W-1:0] ALU_DIV = 4'b1001;
   localparam logic [OP_W-1:0] ALU_REM = 4'b1010;

   // Handshake FSM states
   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_MUL  = 2'd1;
   localparam logic [STATE_W-1:0] ST_DIV  = 2'd2;
   localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

   // Status flags returned with every result
   typedef struct packed {
      logic zero;
      logic carry;
      logic overflow;
      logic div_by_zero;
      logic illegal_op;
   } alu_flags_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply / restoring divide engine, one bit per cycle.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start          one-cycle pulse: load operands and begin WIDTH iterations
//   is_div         0 = unsigned multiply, 1 = unsigned divide (sampled on start)
//   opa, opb       multiplier/multiplicand or dividend/divisor (sampled on start)
//   done           registered one-cycle pulse after the last iteration
//   acc_lo         MUL: low product half;  DIV: quotient
//   acc_hi         MUL: high product half; DIV: unused (zero)
//   rem            DIV: remainder
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             done,
   output logic [WIDTH-1:0] acc_lo,
   output logic [WIDTH-1:0] acc_hi,
   output logic [WIDTH-1:0] rem
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic                 busy;
   logic                 is_div_q;
   logic [CNT_W-1:0]     cnt;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     rem_q;
   logic [WIDTH-1:0]     opb_q;

   logic [WIDTH:0]       mul_sum_c;
   logic [WIDTH:0]       div_shift_c;
   logic [WIDTH:0]       div_diff_c;
   logic                 div_ge_c;

   // Shift-add step: conditionally add multiplicand into the high half
   assign mul_sum_c = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb_q})
                             : {1'b0, acc[2*WIDTH-1:WIDTH]};

   // Restoring step: shift next dividend bit into the (WIDTH+1)-bit partial
   // remainder and trial-subtract; bit WIDTH of the difference is the borrow
   assign div_shift_c = {rem_q, acc[WIDTH-1]};
   assign div_diff_c  = div_shift_c - {1'b0, opb_q};
   assign div_ge_c    = ~div_diff_c[WIDTH];

   // Iteration registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         is_div_q <= 1'b0;
         cnt      <= '0;
         acc      <= '0;
         rem_q    <= '0;
         opb_q    <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            busy     <= 1'b1;
            is_div_q <= is_div;
            cnt      <= CNT_W'(WIDTH);
            acc      <= {{WIDTH{1'b0}}, opa};
            rem_q    <= '0;
            opb_q    <= opb;
         end else if (busy) begin
            if (is_div_q) begin
               rem_q            <= div_ge_c ? div_diff_c[WIDTH-1:0] : div_shift_c[WIDTH-1:0];
               acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], div_ge_c};
            end else begin
               acc <= {mul_sum_c, acc[WIDTH-1:1]};
            end
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign acc_lo = acc[WIDTH-1:0];
   assign acc_hi = acc[2*WIDTH-1:WIDTH];
   assign rem    = rem_q;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU between register-read and write-back with valid/ready on
// both sides. Logic/add/sub finish in one cycle; MUL/DIV/REM iterate.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   request handshake (in_ready high only in IDLE)
//   alu_control           opcode, sampled on accept
//   src1, src2            operands, sampled on accept
//   out_valid / out_ready result handshake; outputs held until consumed
//   result                operation result
//   zero, carry, overflow, div_by_zero, illegal_op   status flags
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             div_by_zero,
   output logic             illegal_op
);

   logic [STATE_W-1:0] state, state_next;
   logic [OP_W-1:0]    op_q, op_next;
   logic [WIDTH-1:0]   a_q, a_next;
   logic [WIDTH-1:0]   b_q, b_next;
   logic [WIDTH-1:0]   result_next;
   alu_flags_t         flags_q, flags_next;
   logic               out_valid_next;
   logic               in_ready_next;

   logic               accept_c;
   logic               start_c;
   logic               fin_c;
   logic [WIDTH-1:0]   fin_result_c;
   alu_flags_t         fin_flags_c;

   logic               iter_done;
   logic [WIDTH-1:0]   iter_lo;
   logic [WIDTH-1:0]   iter_hi;
   logic [WIDTH-1:0]   iter_rem;

   logic [WIDTH:0]     add_sum_c;
   logic [WIDTH:0]     sub_diff_c;

   // Single-cycle arithmetic on latched operands; bit WIDTH is carry/borrow
   assign add_sum_c  = {1'b0, a_q} + {1'b0, b_q};
   assign sub_diff_c = {1'b0, a_q} - {1'b0, b_q};

   assign accept_c = in_valid & in_ready;

   alu_muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start_c),
      .is_div (alu_control != ALU_MUL),
      .opa    (src1),
      .opb    (src2),
      .done   (iter_done),
      .acc_lo (iter_lo),
      .acc_hi (iter_hi),
      .rem    (iter_rem)
   );

   // Next-state and next-output logic
   always_comb begin
      state_next     = state;
      op_next        = op_q;
      a_next         = a_q;
      b_next         = b_q;
      result_next    = result;
      flags_next     = flags_q;
      out_valid_next = out_valid;
      in_ready_next  = in_ready;
      start_c        = 1'b0;
      fin_c          = 1'b0;
      fin_result_c   = '0;
      fin_flags_c    = '0;

      case (state)
         ST_IDLE: begin
            if (accept_c) begin
               op_next       = alu_control;
               a_next        = src1;
               b_next        = src2;
               in_ready_next = 1'b0;
               if (alu_control == ALU_MUL) begin
                  state_next = ST_MUL;
                  start_c    = 1'b1;
               end else if (((alu_control == ALU_DIV) || (alu_control == ALU_REM)) &&
                            (src2 != '0)) begin
                  state_next = ST_DIV;
                  start_c    = 1'b1;
               end else begin
                  // Single-cycle, illegal and divide-by-zero finish in DONE
                  state_next = ST_DONE;
               end
            end
         end

         ST_MUL: begin
            if (iter_done) begin
               fin_c                = 1'b1;
               fin_result_c         = iter_lo;
               fin_flags_c.overflow = |iter_hi;
               state_next           = ST_DONE;
            end
         end

         ST_DIV: begin
            if (iter_done) begin
               fin_c        = 1'b1;
               fin_result_c = (op_q == ALU_REM) ? iter_rem : iter_lo;
               state_next   = ST_DONE;
            end
         end

         ST_DONE: begin
            if (!out_valid) begin
               // First DONE cycle of a non-iterative op: compute and register
               fin_c = 1'b1;
               case (op_q)
                  ALU_ADD: begin
                     fin_result_c         = add_sum_c[WIDTH-1:0];
                     fin_flags_c.carry    = add_sum_c[WIDTH];
                     fin_flags_c.overflow = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                            (add_sum_c[WIDTH-1] != a_q[WIDTH-1]);
                  end
                  ALU_SUB: begin
                     fin_result_c         = sub_diff_c[WIDTH-1:0];
                     fin_flags_c.carry    = sub_diff_c[WIDTH];
                     fin_flags_c.overflow = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                            (sub_diff_c[WIDTH-1] != a_q[WIDTH-1]);
                  end
                  ALU_AND: fin_result_c = a_q & b_q;
                  ALU_OR:  fin_result_c = a_q | b_q;
                  ALU_XOR: fin_result_c = a_q ^ b_q;
                  ALU_DIV: begin
                     fin_result_c            = '1;
                     fin_flags_c.div_by_zero = 1'b1;
                  end
                  ALU_REM: begin
                     fin_result_c            = a_q;
                     fin_flags_c.div_by_zero = 1'b1;
                  end
                  default: fin_flags_c.illegal_op = 1'b1;
               endcase
            end else if (out_ready) begin
               out_valid_next = 1'b0;
               in_ready_next  = 1'b1;
               state_next     = ST_IDLE;
            end
         end

         default: begin
            state_next     = ST_IDLE;
            out_valid_next = 1'b0;
            in_ready_next  = 1'b1;
         end
      endcase

      // zero always derives from the final result being registered
      if (fin_c) begin
         result_next     = fin_result_c;
         flags_next      = fin_flags_c;
         flags_next.zero = (fin_result_c == '0);
         out_valid_next  = 1'b1;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         result    <= '0;
         flags_q   <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         state     <= state_next;
         op_q      <= op_next;
         a_q       <= a_next;
         b_q       <= b_next;
         result    <= result_next;
         flags_q   <= flags_next;
         out_valid <= out_valid_next;
         in_ready  <= in_ready_next;
      end
   end

   assign zero        = flags_q.zero;
   assign carry       = flags_q.carry;
   assign overflow    = flags_q.overflow;
   assign div_by_zero = flags_q.div_by_zero;
   assign illegal_op  = flags_q.illegal_op;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32): expected result, flags and
// latency are pushed when a request is driven and popped when out_valid rises.
module tb_alu_seq;

   localparam int unsigned W = 32;

   typedef struct {
      logic [W-1:0] result;
      logic [4:0]   flags;   // {zero, carry, overflow, div_by_zero, illegal_op}
      int           lat;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   alu_control;
   logic [W-1:0] src1;
   logic [W-1:0] src2;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         zero;
   logic         carry;
   logic         overflow;
   logic         div_by_zero;
   logic         illegal_op;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   alu_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .src1        (src1),
      .src2        (src2),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .carry       (carry),
      .overflow    (overflow),
      .div_by_zero (div_by_zero),
      .illegal_op  (illegal_op)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model using native arithmetic
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      exp_t        e;
      logic [W:0]  s;
      logic [63:0] p;
      longint      sd;
      logic        c, v, d, il;
      e.result = '0;
      e.lat    = 1;
      c = 1'b0; v = 1'b0; d = 1'b0; il = 1'b0;
      case (op)
         4'b0010: begin
            s        = 33'(a) + 33'(b);
            e.result = s[W-1:0];
            c        = s[W];
            sd       = longint'($signed(a)) + longint'($signed(b));
            v        = (sd != longint'($signed(e.result)));
         end
         4'b0110: begin
            e.result = a - b;
            c        = (a < b);
            sd       = longint'($signed(a)) - longint'($signed(b));
            v        = (sd != longint'($signed(e.result)));
         end
         4'b0000: e.result = a & b;
         4'b0001: e.result = a | b;
         4'b0011: e.result = a ^ b;
         4'b1000: begin
            p        = 64'(a) * 64'(b);
            e.result = p[W-1:0];
            v        = (p[63:32] != 32'd0);
            e.lat    = W + 1;
         end
         4'b1001: begin
            if (b == '0) begin e.result = '1; d = 1'b1; end
            else begin e.result = a / b; e.lat = W + 1; end
         end
         4'b1010: begin
            if (b == '0) begin e.result = a; d = 1'b1; end
            else begin e.result = a % b; e.lat = W + 1; end
         end
         default: il = 1'b1;
      endcase
      e.flags = {(e.result == '0), c, v, d, il};
      return e;
   endfunction

   // Issue one op, wait (bounded) for its result, check it, optionally hold out_ready low
   task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
      exp_t         e;
      int           n;
      logic [W-1:0] held;
      @(negedge clk);
      check("in_ready_idle", 64'(in_ready), 64'(1));
      in_valid    = 1'b1;
      alu_control = op;
      src1        = a;
      src2        = b;
      out_ready   = (hold == 0);
      sb.push_back(model(op, a, b));
      @(negedge clk);
      in_valid    = 1'b0;
      alu_control = 4'($urandom);
      src1        = $urandom;
      src2        = $urandom;
      check("in_ready_busy", 64'(in_ready), 64'(0));
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      e = sb.pop_front();
      check("latency", 64'(n), 64'(e.lat));
      check("result", 64'(result), 64'(e.result));
      check("flags", 64'({zero, carry, overflow, div_by_zero, illegal_op}), 64'(e.flags));
      if (hold > 0) begin
         held = result;
         for (int i = 0; i < hold; i++) begin
            in_valid    = 1'b1;
            alu_control = 4'b0010;
            src1        = $urandom;
            src2        = $urandom;
            @(negedge clk);
            check("hold_result", 64'(result), 64'(held));
            check("hold_out_valid", 64'(out_valid), 64'(1));
            check("hold_in_ready", 64'(in_ready), 64'(0));
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(negedge clk);
      check("consumed_out_valid", 64'(out_valid), 64'(0));
      check("consumed_in_ready", 64'(in_ready), 64'(1));
   endtask

   initial begin
      logic [3:0] ops [8];
      logic [W-1:0] ra, rb;
      ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b1000, 4'b1001, 4'b1010};

      rst_n       = 1'b0;
      in_valid    = 1'b0;
      alu_control = '0;
      src1        = '0;
      src2        = '0;
      out_ready   = 1'b1;
      #12;
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_result", 64'(result), 64'(0));
      check("rst_flags", 64'({zero, carry, overflow, div_by_zero, illegal_op}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Reset in the middle of a multiply discards it
      @(negedge clk);
      in_valid    = 1'b1;
      alu_control = 4'b1000;
      src1        = 32'h1234_5678;
      src2        = 32'h0000_0321;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_in_ready", 64'(in_ready), 64'(1));
      check("midrst_result", 64'(result), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("midrst_no_output", 64'(out_valid), 64'(0));

      // Directed boundary cases
      do_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      do_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
      do_op(4'b0110, 32'h8000_0000, 32'h0000_0001, 0);
      do_op(4'b0110, 32'h0000_0003, 32'h0000_0005, 0);
      do_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
      do_op(4'b0001, 32'hF000_0000, 32'h0000_000F, 0);
      do_op(4'b0011, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0);
      do_op(4'b1000, 32'h0001_0000, 32'h0001_0000, 0);
      do_op(4'b1000, 32'h0000_FFFF, 32'h0000_FFFF, 0);
      do_op(4'b1001, 32'd100, 32'd7, 0);
      do_op(4'b1010, 32'd100, 32'd7, 0);
      do_op(4'b1001, 32'd5, 32'd0, 0);
      do_op(4'b1010, 32'd5, 32'd0, 0);
      do_op(4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      do_op(4'b1001, 32'h0000_0006, 32'hFFFF_FFFF, 0);
      do_op(4'b1010, 32'h8000_0000, 32'h0000_0003, 0);
      do_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0);

      // Output stall: result held, new requests ignored
      do_op(4'b1000, 32'h0000_1234, 32'h0000_5678, 10);

      // Random operands over every legal opcode
      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         do_op(ops[i % 8], ra, rb, 0);
      end

      check("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "timeout");
   end

endmodule
